// File: rtl/cpu_pkg.sv
// Shared encodings for the switch-board accumulator CPU.
package cpu_pkg;
    localparam logic [1:0] OP_ADD    = 2'b00;
    localparam logic [1:0] OP_SUB    = 2'b01;
    localparam logic [1:0] OP_STR    = 2'b10;
    localparam logic [1:0] OP_AND    = 2'b11;
    localparam logic       MODE_LOAD = 1'b0;
    localparam logic       MODE_EXEC = 1'b1;
endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: add with carry-out, subtract with borrow, pass-through, bitwise AND.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             y_zero
);
    logic [WIDTH:0] sum;

    assign sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        y    = a;
        cout = 1'b0;
        case (op)
            OP_ADD: {cout, y} = sum;
            OP_SUB: begin
                y    = a - b;
                cout = (a < b);
            end
            OP_STR: y = a;
            OP_AND: y = a & b;
            default: y = a;
        endcase
    end

    assign y_zero = (y == '0);
endmodule

// File: rtl/cpu.sv
// Switch-driven accumulator CPU: LOAD an immediate nibble or EXECUTE an instruction
// against ACC and a 4-entry register file, one action per enabled clock edge.
module cpu
    import cpu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             SW1,
    input  logic             SW2,
    input  logic             SW3,
    input  logic             SW4,
    input  logic             operation,
    input  logic             enable,
    output logic [WIDTH-1:0] acc,
    output logic             carry,
    output logic             zero,
    output logic             done
);
    logic [3:0]       sw;
    logic [1:0]       op;
    logic [1:0]       rsel;
    logic [WIDTH-1:0] regs [4];
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] alu_y;
    logic             alu_cout;
    logic             alu_zero;

    assign sw   = {SW4, SW3, SW2, SW1};
    assign op   = sw[3:2];
    assign rsel = sw[1:0];
    assign imm  = WIDTH'(sw);

    cpu_alu #(.WIDTH(WIDTH)) u_alu (
        .a      (acc),
        .b      (regs[rsel]),
        .op     (op),
        .y      (alu_y),
        .cout   (alu_cout),
        .y_zero (alu_zero)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            acc   <= '0;
            carry <= 1'b0;
            zero  <= 1'b1;
            done  <= 1'b0;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else if (enable) begin
            done <= 1'b1;
            if (operation == MODE_LOAD) begin
                acc  <= imm;
                zero <= (imm == '0);
            end else begin
                // STR only writes the register file; flags keep their value.
                case (op)
                    OP_ADD, OP_SUB: begin
                        acc   <= alu_y;
                        carry <= alu_cout;
                        zero  <= alu_zero;
                    end
                    OP_AND: begin
                        acc  <= alu_y;
                        zero <= alu_zero;
                    end
                    default: regs[rsel] <= acc;
                endcase
            end
        end else begin
            done <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cpu.sv
// Bench for cpu: directed vector table, a few hand sequences, then random
// stimulus against an arithmetic reference model.
module tb_cpu;
    logic       clock = 1'b0;
    logic       reset_n;
    logic       SW1, SW2, SW3, SW4;
    logic       operation;
    logic       enable;
    logic [3:0] acc;
    logic       carry;
    logic       zero;
    logic       done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       opr;
        logic [3:0] sw;
        logic [3:0] e_acc;
        logic       e_carry;
        logic       e_zero;
        logic       e_done;
    } vec_t;

    vec_t vecs[$];

    cpu #(.WIDTH(4)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .SW1       (SW1),
        .SW2       (SW2),
        .SW3       (SW3),
        .SW4       (SW4),
        .operation (operation),
        .enable    (enable),
        .acc       (acc),
        .carry     (carry),
        .zero      (zero),
        .done      (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_sw(input logic [3:0] s);
        {SW4, SW3, SW2, SW1} = s;
    endtask

    // Drive at the falling edge, let the rising edge act, sample 1 time unit later.
    task automatic step(input logic r, input logic e, input logic o, input logic [3:0] s);
        @(negedge clock);
        reset_n   = r;
        enable    = e;
        operation = o;
        set_sw(s);
        @(posedge clock);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [3:0] ea, input logic ec,
                             input logic ez, input logic ed);
        check({tag, ".acc"},   {4'h0, acc},   {4'h0, ea});
        check({tag, ".carry"}, {7'h0, carry}, {7'h0, ec});
        check({tag, ".zero"},  {7'h0, zero},  {7'h0, ez});
        check({tag, ".done"},  {7'h0, done},  {7'h0, ed});
    endtask

    task automatic add(input logic r, input logic e, input logic o, input logic [3:0] s,
                       input logic [3:0] ea, input logic ec, input logic ez, input logic ed);
        vec_t v;
        v.rst_n = r; v.en = e; v.opr = o; v.sw = s;
        v.e_acc = ea; v.e_carry = ec; v.e_zero = ez; v.e_done = ed;
        vecs.push_back(v);
    endtask

    initial begin
        int m_acc;
        int m_r[4];
        int m_carry;
        int m_done;
        logic       r, e, o;
        logic [3:0] s;
        int idx;

        reset_n = 1'b0; enable = 1'b0; operation = 1'b0; set_sw(4'h0);

        //   rst en op  sw      acc   c  z  d
        add(0, 0, 0, 4'h0,    4'h0, 0, 1, 0);  // plain reset
        add(0, 1, 0, 4'h5,    4'h0, 0, 1, 0);  // reset wins over enable
        add(1, 0, 0, 4'h2,    4'h0, 0, 1, 0);  // hold x3
        add(1, 0, 0, 4'h2,    4'h0, 0, 1, 0);
        add(1, 0, 0, 4'h2,    4'h0, 0, 1, 0);
        add(1, 1, 0, 4'h2,    4'h2, 0, 0, 1);  // LOAD 2
        add(1, 1, 1, 4'b1001, 4'h2, 0, 0, 1);  // STR R1
        add(1, 0, 1, 4'b1001, 4'h2, 0, 0, 0);  // idle: done drops
        add(1, 1, 0, 4'hF,    4'hF, 0, 0, 1);  // LOAD F
        add(1, 1, 1, 4'b1000, 4'hF, 0, 0, 1);  // STR R0
        add(1, 1, 0, 4'h1,    4'h1, 0, 0, 1);  // LOAD 1
        add(1, 1, 1, 4'b0000, 4'h0, 1, 1, 1);  // ADD R0 overflow
        add(1, 1, 0, 4'h3,    4'h3, 1, 0, 1);  // LOAD keeps carry
        add(1, 1, 1, 4'b1010, 4'h3, 1, 0, 1);  // STR R2
        add(1, 1, 0, 4'h1,    4'h1, 1, 0, 1);  // LOAD 1
        add(1, 1, 1, 4'b0110, 4'hE, 1, 0, 1);  // SUB R2 borrow
        add(1, 1, 1, 4'b0001, 4'h0, 1, 1, 1);  // ADD R1: E+2 wraps
        add(1, 1, 0, 4'h5,    4'h5, 1, 0, 1);  // LOAD 5
        add(1, 1, 1, 4'b1011, 4'h5, 1, 0, 1);  // STR R3
        add(1, 1, 0, 4'hF,    4'hF, 1, 0, 1);  // LOAD F
        add(1, 1, 1, 4'b1111, 4'h5, 1, 0, 1);  // AND R3
        add(1, 1, 1, 4'b0101, 4'h3, 0, 0, 1);  // SUB R1, no borrow
        add(1, 1, 1, 4'b0111, 4'h0, 0, 1, 1);  // SUB R3: 3-5? no: see below
        vecs.delete(vecs.size() - 1);
        add(1, 1, 1, 4'b0111, 4'hE, 1, 0, 1);  // SUB R3: 3-5 = E, borrow
        add(0, 1, 1, 4'b1111, 4'h0, 0, 1, 0);  // reset mid-run
        add(1, 1, 0, 4'h7,    4'h7, 0, 0, 1);  // LOAD 7
        add(1, 1, 1, 4'b0011, 4'h7, 0, 0, 1);  // ADD R3: register file was cleared
        add(1, 1, 1, 4'b1100, 4'h0, 0, 1, 1);  // AND R0 (cleared) -> 0

        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].en, vecs[i].opr, vecs[i].sw);
            check_all($sformatf("vec%0d", i), vecs[i].e_acc, vecs[i].e_carry,
                      vecs[i].e_zero, vecs[i].e_done);
        end

        // Switch glitches between edges must not matter; only the level at the edge counts.
        @(negedge clock);
        reset_n = 1'b1; enable = 1'b1; operation = 1'b0; set_sw(4'h4);
        #2 set_sw(4'h9);
        #2 set_sw(4'h4);
        @(posedge clock); #1;
        check_all("glitch_load", 4'h4, 1'b0, 1'b0, 1'b1);
        @(negedge clock);
        enable = 1'b0; set_sw(4'hB);
        #2 operation = 1'b1;
        @(posedge clock); #1;
        check_all("glitch_hold", 4'h4, 1'b0, 1'b0, 1'b0);
        // Back-to-back actions keep done high across consecutive edges.
        step(1, 1, 0, 4'h8);
        check_all("b2b_1", 4'h8, 1'b0, 1'b0, 1'b1);
        step(1, 1, 0, 4'h0);
        check_all("b2b_2", 4'h0, 1'b0, 1'b1, 1'b1);

        // Random phase: start from reset so the model is aligned.
        m_acc = 0; m_carry = 0; m_done = 0;
        for (int k = 0; k < 4; k++) m_r[k] = 0;
        for (int n = 0; n < 400; n++) begin
            r = (n == 0) ? 1'b0 : ($urandom_range(0, 24) != 0);
            e = ($urandom_range(0, 3) != 0);
            o = 1'($urandom_range(0, 1));
            s = 4'($urandom_range(0, 15));
            step(r, e, o, s);
            idx = int'(s[1:0]);
            if (!r) begin
                m_acc = 0; m_carry = 0; m_done = 0;
                for (int k = 0; k < 4; k++) m_r[k] = 0;
            end else if (!e) begin
                m_done = 0;
            end else begin
                m_done = 1;
                if (!o) m_acc = int'(s);
                else begin
                    case (int'(s[3:2]))
                        0: begin
                            m_carry = (m_acc + m_r[idx] > 15) ? 1 : 0;
                            m_acc   = (m_acc + m_r[idx]) % 16;
                        end
                        1: begin
                            m_carry = (m_acc < m_r[idx]) ? 1 : 0;
                            m_acc   = (m_acc - m_r[idx] + 16) % 16;
                        end
                        2: m_r[idx] = m_acc;
                        default: m_acc = m_acc & m_r[idx];
                    endcase
                end
            end
            check_all($sformatf("rnd%0d", n), 4'(m_acc), 1'(m_carry),
                      (m_acc == 0), 1'(m_done));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
